// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-unit signal bundle.
// The pipeline side uses the master modport and the hazard controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 4
);
    logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E;
    logic [REG_AW-1:0] WA3E, WA3M, WA3W;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE, PCSrcE;
    logic              StallF, StallD, FlushD, FlushE, Busy;
    logic [1:0]        FwdAE, FwdBE;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, Busy, FwdAE, FwdBE
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE,
        output StallF, StallD, FlushD, FlushE, Busy, FwdAE, FwdBE
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding selects, load-use stall FSM and branch flush control.
// Define HAZARD_PERF_CNT_EN to add the StallCnt/FlushCnt performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 4,
    parameter int MEM_LAT = 1,
    parameter int PC_IDX  = 15
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
`endif
);
    localparam logic [REG_AW-1:0] PC       = REG_AW'(PC_IDX);
    localparam logic [3:0]        CNT_INIT = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

    typedef enum logic {IDLE, LDSTALL} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       lu, stall, flush;

    // M holds the younger result, so it takes priority over W.
    assign hz.FwdAE = (hz.RegWriteM && hz.WA3M == hz.RA1E && hz.RA1E != PC) ? 2'b10 :
                      (hz.RegWriteW && hz.WA3W == hz.RA1E && hz.RA1E != PC) ? 2'b01 : 2'b00;
    assign hz.FwdBE = (hz.RegWriteM && hz.WA3M == hz.RA2E && hz.RA2E != PC) ? 2'b10 :
                      (hz.RegWriteW && hz.WA3W == hz.RA2E && hz.RA2E != PC) ? 2'b01 : 2'b00;

    assign lu    = hz.MemtoRegE && hz.RegWriteE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
    assign stall = !rst && !hz.PCSrcE && (state == LDSTALL || lu);
    assign flush = !rst && hz.PCSrcE;

    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushD = flush;
    assign hz.FlushE = stall || flush;
    assign hz.Busy   = !rst && state == LDSTALL;

    // The first stall cycle is spent in IDLE, so LDSTALL covers the remaining MEM_LAT-1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (hz.PCSrcE) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            if (lu && MEM_LAT > 1) begin
                state_n = LDSTALL;
                cnt_n   = CNT_INIT;
            end
        end else if (cnt == '0) begin
            state_n = IDLE;
        end else begin
            cnt_n = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            StallCnt <= StallCnt + 32'(stall);
            FlushCnt <= FlushCnt + 32'(hz.PCSrcE);
        end
    end
`endif
endmodule
